// File: rtl/playback_ctrl_if.sv
// Button, counter-feedback and control bundle between the playback sequencer and the counter side.
// Purely combinational wiring; it adds no latency.
// There is no flow control: every signal is a level or a single-cycle pulse.
interface playback_ctrl_if;
  logic       tick_1hz;
  logic       btn_play;
  logic       btn_skip;
  logic       btn_stop;
  logic [5:0] cur_mins;
  logic [5:0] cur_secs;
  logic       ss;
  logic       ispaused;
  logic       ctr_rst;
  logic       song_done;
  logic [1:0] state;

  // Sequencer side: consumes buttons and counter time, drives counter control
  modport master (
    input  tick_1hz, btn_play, btn_skip, btn_stop, cur_mins, cur_secs,
    output ss, ispaused, ctr_rst, song_done, state
  );

  // Debouncer/counter side: the mirror image
  modport slave (
    output tick_1hz, btn_play, btn_skip, btn_stop, cur_mins, cur_secs,
    input  ss, ispaused, ctr_rst, song_done, state
  );
endinterface

// File: rtl/playback_ctrl.sv
// Playback sequencer: turns button pulses into song select, pause and counter clear; auto-advances at end of song.
// Latency: every output is registered and responds on the clk edge after the triggering input cycle.
// No backpressure; buttons are single-cycle pulses. Build option LOOP_EN loops back to song 0 after song 1 instead of stopping.
module playback_ctrl #(
  parameter int LEN0_MIN = 3,
  parameter int LEN0_SEC = 20,
  parameter int LEN1_MIN = 2,
  parameter int LEN1_SEC = 45
) (
  input logic             clk,
  input logic             RESET,
  playback_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    STOP   = 2'b00,
    PLAY   = 2'b01,
    PAUSE  = 2'b10,
    CHANGE = 2'b11
  } state_t;

  // Song lengths as {minutes, seconds}; with both fields below 60 this orders like real time
  localparam logic [11:0] END0 = {6'(LEN0_MIN), 6'(LEN0_SEC)};
  localparam logic [11:0] END1 = {6'(LEN1_MIN), 6'(LEN1_SEC)};

  state_t st;
  logic   ss_q;
  logic   ispaused_q;
  logic   ctr_rst_q;
  logic   song_done_q;
  logic   song_end;

  // End of song is only meaningful while playing; stale counter values elsewhere are ignored
  always_comb begin
    song_end = 1'b0;
    if (st == PLAY)
      song_end = ({bus.cur_mins, bus.cur_secs} >= (ss_q ? END1 : END0));
  end

  // Sequencer FSM; stop > skip > play, and any button beats end-of-song detection in the same cycle.
  // ctr_rst is requested as ~ctr_rst_q so a clear can never stretch over two consecutive cycles.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      st          <= STOP;
      ss_q        <= 1'b0;
      ispaused_q  <= 1'b1;
      ctr_rst_q   <= 1'b0;
      song_done_q <= 1'b0;
    end else begin
      ctr_rst_q   <= 1'b0;
      song_done_q <= 1'b0;
      if (bus.btn_stop) begin
        st         <= STOP;
        ss_q       <= 1'b0;
        ispaused_q <= 1'b1;
        ctr_rst_q  <= ~ctr_rst_q;
      end else begin
        case (st)
          STOP: begin
            if (bus.btn_skip) begin
              ss_q      <= ~ss_q;
              ctr_rst_q <= ~ctr_rst_q;
            end else if (bus.btn_play) begin
              st         <= PLAY;
              ispaused_q <= 1'b0;
            end
          end
          PLAY: begin
            if (bus.btn_skip) begin
              ss_q       <= ~ss_q;
              st         <= CHANGE;
              ispaused_q <= 1'b1;
            end else if (bus.btn_play) begin
              st         <= PAUSE;
              ispaused_q <= 1'b1;
            end else if (song_end) begin
              song_done_q <= 1'b1;
              ispaused_q  <= 1'b1;
              if (!ss_q) begin
                ss_q <= 1'b1;
                st   <= CHANGE;
              end else begin
                ss_q      <= 1'b0;
                ctr_rst_q <= ~ctr_rst_q;
`ifdef LOOP_EN
                st        <= CHANGE;
`else
                st        <= STOP;
`endif
              end
            end
          end
          PAUSE: begin
            if (bus.btn_skip) begin
              ss_q <= ~ss_q;
              st   <= CHANGE;
            end else if (bus.btn_play) begin
              st         <= PLAY;
              ispaused_q <= 1'b0;
            end
          end
          CHANGE: begin
            // Hold paused until the counter's next 1 Hz boundary so the new song starts on a whole second
            if (bus.btn_skip) begin
              ss_q <= ~ss_q;
            end else if (bus.tick_1hz) begin
              st         <= PLAY;
              ispaused_q <= 1'b0;
            end
          end
          default: begin
            st         <= STOP;
            ispaused_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.ss        = ss_q;
  assign bus.ispaused  = ispaused_q;
  assign bus.ctr_rst   = ctr_rst_q;
  assign bus.song_done = song_done_q;
  assign bus.state     = st;

endmodule

// File: tb/tb_playback_ctrl.sv
// Self-checking bench for playback_ctrl with short song lengths (song 0 = 0:03, song 1 = 0:02).
// Each scenario task drives a stimulus table, queues the expected outputs and checks them one edge later.
// Build with or without LOOP_EN; the end-of-song-1 expectations follow the macro.
module tb_playback_ctrl;

  typedef struct packed {
    logic [1:0] st;
    logic       ss;
    logic       isp;
    logic       crst;
    logic       done;
  } out_t;

  typedef struct packed {
    logic       play;
    logic       skip;
    logic       stop;
    logic       tick;
    logic [5:0] mins;
    logic [5:0] secs;
    out_t       exp;
  } row_t;

  localparam logic [1:0] S_STOP = 2'b00, S_PLAY = 2'b01, S_PAUSE = 2'b10, S_CHG = 2'b11;

  logic clk = 1'b0;
  logic RESET = 1'b1;
  int   errors = 0;
  int   checks = 0;
  out_t sb[$];

  playback_ctrl_if bus();

  playback_ctrl #(
    .LEN0_MIN(0), .LEN0_SEC(3), .LEN1_MIN(0), .LEN1_SEC(2)
  ) dut (
    .clk  (clk),
    .RESET(RESET),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic out_t sample();
    return '{bus.state, bus.ss, bus.ispaused, bus.ctr_rst, bus.song_done};
  endfunction

  function automatic out_t O(input logic [1:0] st, input logic ss, input logic isp,
                             input logic crst, input logic done);
    return '{st, ss, isp, crst, done};
  endfunction

  function automatic row_t R(input logic p, input logic k, input logic s, input logic t,
                             input int m, input int sec, input out_t e);
    return '{p, k, s, t, 6'(m), 6'(sec), e};
  endfunction

  task automatic idle_inputs();
    bus.btn_play = 1'b0;
    bus.btn_skip = 1'b0;
    bus.btn_stop = 1'b0;
    bus.tick_1hz = 1'b0;
  endtask

  // Apply one row for one cycle, record its expectation, and land #1 after the edge
  task automatic drive(input row_t r);
    bus.btn_play = r.play;
    bus.btn_skip = r.skip;
    bus.btn_stop = r.stop;
    bus.tick_1hz = r.tick;
    bus.cur_mins = r.mins;
    bus.cur_secs = r.secs;
    sb.push_back(r.exp);
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic test_reset();
    row_t rows[$];
    out_t got, e;
    repeat (2) @(posedge clk);
    #1;
    sb.push_back(O(S_STOP, 0, 1, 0, 0));
    got = sample(); e = sb.pop_front(); checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL rst_init: got %b expected %b", got, e);
    end
    RESET = 1'b0;
    // Reach PLAY on song 1, then reset asynchronously mid-cycle
    rows.push_back(R(0, 1, 0, 0, 0, 0, O(S_STOP, 1, 1, 1, 0)));
    rows.push_back(R(0, 0, 0, 0, 0, 0, O(S_STOP, 1, 1, 0, 0)));
    rows.push_back(R(1, 0, 0, 0, 0, 0, O(S_PLAY, 1, 0, 0, 0)));
    foreach (rows[i]) begin
      drive(rows[i]);
      got = sample(); e = sb.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL rst_setup[%0d]: got %b expected %b", i, got, e);
      end
    end
    #3;
    RESET = 1'b1;
    sb.push_back(O(S_STOP, 0, 1, 0, 0));
    #1;
    got = sample(); e = sb.pop_front(); checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL rst_mid_play: got %b expected %b", got, e);
    end
    @(posedge clk);
    #1;
    RESET = 1'b0;
    // A pending ctr_rst pulse must be cut short by reset
    rows.delete();
    rows.push_back(R(1, 0, 0, 0, 0, 0, O(S_PLAY, 0, 0, 0, 0)));
    rows.push_back(R(0, 0, 1, 0, 0, 0, O(S_STOP, 0, 1, 1, 0)));
    foreach (rows[i]) begin
      drive(rows[i]);
      got = sample(); e = sb.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL rst_stop[%0d]: got %b expected %b", i, got, e);
      end
    end
    #2;
    RESET = 1'b1;
    sb.push_back(O(S_STOP, 0, 1, 0, 0));
    #1;
    got = sample(); e = sb.pop_front(); checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL rst_cancel: got %b expected %b", got, e);
    end
    @(posedge clk);
    #1;
    RESET = 1'b0;
  endtask

  task automatic test_play_pause();
    row_t rows[$];
    out_t got, e;
    rows.push_back(R(1, 0, 0, 0, 0, 0, O(S_PLAY,  0, 0, 0, 0)));
    rows.push_back(R(1, 0, 0, 0, 0, 0, O(S_PAUSE, 0, 1, 0, 0)));
    rows.push_back(R(0, 0, 0, 0, 0, 0, O(S_PAUSE, 0, 1, 0, 0)));
    rows.push_back(R(1, 0, 0, 0, 0, 0, O(S_PLAY,  0, 0, 0, 0)));
    rows.push_back(R(1, 0, 0, 0, 0, 0, O(S_PAUSE, 0, 1, 0, 0)));
    rows.push_back(R(0, 0, 1, 0, 0, 0, O(S_STOP,  0, 1, 1, 0)));
    rows.push_back(R(0, 0, 0, 0, 0, 0, O(S_STOP,  0, 1, 0, 0)));
    foreach (rows[i]) begin
      drive(rows[i]);
      got = sample(); e = sb.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL play_pause[%0d]: got %b expected %b", i, got, e);
      end
    end
  endtask

  task automatic test_change();
    row_t rows[$];
    out_t got, e;
    rows.push_back(R(1, 0, 0, 0, 0, 0, O(S_PLAY, 0, 0, 0, 0)));
    rows.push_back(R(0, 1, 0, 0, 0, 0, O(S_CHG,  1, 1, 0, 0)));
    for (int n = 0; n < 50; n++)
      rows.push_back(R(0, 0, 0, 0, 0, 0, O(S_CHG, 1, 1, 0, 0)));
    rows.push_back(R(0, 0, 0, 1, 0, 0, O(S_PLAY, 1, 0, 0, 0)));
    rows.push_back(R(0, 1, 0, 0, 0, 0, O(S_CHG,  0, 1, 0, 0)));
    rows.push_back(R(0, 1, 0, 0, 0, 0, O(S_CHG,  1, 1, 0, 0)));
    rows.push_back(R(1, 0, 0, 0, 0, 0, O(S_CHG,  1, 1, 0, 0)));
    rows.push_back(R(0, 1, 0, 1, 0, 0, O(S_CHG,  0, 1, 0, 0)));
    rows.push_back(R(0, 0, 0, 1, 0, 0, O(S_PLAY, 0, 0, 0, 0)));
    rows.push_back(R(1, 0, 0, 0, 0, 0, O(S_PAUSE, 0, 1, 0, 0)));
    rows.push_back(R(0, 1, 0, 0, 0, 0, O(S_CHG,  1, 1, 0, 0)));
    rows.push_back(R(0, 0, 1, 0, 0, 0, O(S_STOP, 0, 1, 1, 0)));
    rows.push_back(R(0, 0, 0, 0, 0, 0, O(S_STOP, 0, 1, 0, 0)));
    foreach (rows[i]) begin
      drive(rows[i]);
      got = sample(); e = sb.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL change[%0d]: got %b expected %b", i, got, e);
      end
    end
  endtask

  task automatic test_end_of_song();
    row_t rows[$];
    out_t got, e;
    logic [1:0] end1_st;
`ifdef LOOP_EN
    end1_st = S_CHG;
`else
    end1_st = S_STOP;
`endif
    rows.push_back(R(1, 0, 0, 0, 0, 0, O(S_PLAY, 0, 0, 0, 0)));
    rows.push_back(R(0, 0, 0, 0, 0, 2, O(S_PLAY, 0, 0, 0, 0)));
    rows.push_back(R(0, 0, 0, 0, 0, 3, O(S_CHG,  1, 1, 0, 1)));
    for (int n = 0; n < 3; n++)
      rows.push_back(R(0, 0, 0, 0, 0, 3, O(S_CHG, 1, 1, 0, 0)));
    rows.push_back(R(0, 0, 0, 1, 0, 0, O(S_PLAY, 1, 0, 0, 0)));
    rows.push_back(R(0, 0, 0, 0, 0, 1, O(S_PLAY, 1, 0, 0, 0)));
    rows.push_back(R(0, 0, 0, 0, 0, 2, O(end1_st, 0, 1, 1, 1)));
    rows.push_back(R(0, 0, 0, 0, 0, 2, O(end1_st, 0, 1, 0, 0)));
`ifdef LOOP_EN
    rows.push_back(R(0, 0, 0, 1, 0, 0, O(S_PLAY, 0, 0, 0, 0)));
    rows.push_back(R(0, 0, 1, 0, 0, 0, O(S_STOP, 0, 1, 1, 0)));
    rows.push_back(R(0, 0, 0, 0, 0, 0, O(S_STOP, 0, 1, 0, 0)));
`endif
    // A button in the end-of-song cycle wins; the end is seen again once back in PLAY
    rows.push_back(R(1, 0, 0, 0, 0, 0, O(S_PLAY,  0, 0, 0, 0)));
    rows.push_back(R(1, 0, 0, 0, 0, 3, O(S_PAUSE, 0, 1, 0, 0)));
    rows.push_back(R(1, 0, 0, 0, 0, 3, O(S_PLAY,  0, 0, 0, 0)));
    rows.push_back(R(0, 0, 0, 0, 0, 3, O(S_CHG,   1, 1, 0, 1)));
    rows.push_back(R(0, 0, 1, 0, 0, 0, O(S_STOP,  0, 1, 1, 0)));
    rows.push_back(R(0, 0, 0, 0, 0, 0, O(S_STOP,  0, 1, 0, 0)));
    foreach (rows[i]) begin
      drive(rows[i]);
      got = sample(); e = sb.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL end_of_song[%0d]: got %b expected %b", i, got, e);
      end
    end
  endtask

  task automatic test_priority();
    row_t rows[$];
    out_t got, e;
    rows.push_back(R(0, 1, 0, 0, 0, 0, O(S_STOP, 1, 1, 1, 0)));
    rows.push_back(R(0, 0, 0, 0, 0, 0, O(S_STOP, 1, 1, 0, 0)));
    rows.push_back(R(1, 0, 0, 0, 0, 0, O(S_PLAY, 1, 0, 0, 0)));
    rows.push_back(R(1, 1, 1, 0, 0, 0, O(S_STOP, 0, 1, 1, 0)));
    rows.push_back(R(0, 0, 0, 0, 0, 0, O(S_STOP, 0, 1, 0, 0)));
    rows.push_back(R(1, 0, 0, 0, 0, 0, O(S_PLAY, 0, 0, 0, 0)));
    rows.push_back(R(1, 1, 0, 0, 0, 0, O(S_CHG,  1, 1, 0, 0)));
    rows.push_back(R(1, 0, 0, 0, 0, 0, O(S_CHG,  1, 1, 0, 0)));
    rows.push_back(R(0, 0, 1, 0, 0, 0, O(S_STOP, 0, 1, 1, 0)));
    rows.push_back(R(0, 0, 1, 0, 0, 0, O(S_STOP, 0, 1, 0, 0)));
    rows.push_back(R(1, 0, 0, 0, 0, 0, O(S_PLAY, 0, 0, 0, 0)));
    rows.push_back(R(0, 0, 1, 0, 0, 0, O(S_STOP, 0, 1, 1, 0)));
    rows.push_back(R(0, 0, 0, 0, 0, 0, O(S_STOP, 0, 1, 0, 0)));
    foreach (rows[i]) begin
      drive(rows[i]);
      got = sample(); e = sb.pop_front(); checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL priority[%0d]: got %b expected %b", i, got, e);
      end
    end
  endtask

  initial begin
    idle_inputs();
    bus.cur_mins = '0;
    bus.cur_secs = '0;
    test_reset();
    test_play_pause();
    test_change();
    test_end_of_song();
    test_priority();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
